// File: rtl/sum_tx_sequencer.sv
// Streams DEPTH beamformed sum words from the sum RAM to the UART transmitter,
// MSB byte first, using the tx_en/tx_rdy handshake.
module sum_tx_sequencer #(
    parameter int DEPTH  = 768,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 40,
    parameter int BYTES  = 5,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_cnt
);

    localparam int BI_W = $clog2(BYTES + 1);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT_RD, LOAD, SEND, GUARD, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [7:0]        wait_q, wait_d;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_en_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        wait_d     = wait_q;
        if (abort) begin
            // Byte already strobed stays on tx_data; everything else unwinds.
            state_d    = IDLE;
            rd_addr_d  = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            word_cnt_d = '0;
            byte_idx_d = '0;
            wait_d     = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d    = READ;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        word_cnt_d = '0;
                        rd_addr_d  = '0;
                        rd_en_d    = 1'b1;
                    end
                end
                READ: begin
                    wait_d  = 8'd1;
                    state_d = (RD_LAT == 1) ? LOAD : WAIT_RD;
                end
                WAIT_RD: begin
                    if (wait_q >= 8'(RD_LAT - 1)) state_d = LOAD;
                    else wait_d = wait_q + 8'd1;
                end
                LOAD: begin
                    shift_d    = rd_data;
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
                SEND: begin
                    if (tx_rdy) begin
                        tx_data_d  = shift_q[DATA_W-1 -: 8];
                        tx_en_d    = 1'b1;
                        shift_d    = shift_q << 8;
                        byte_idx_d = byte_idx_q + BI_W'(1);
                        state_d    = GUARD;
                    end
                end
                GUARD: begin
                    if (byte_idx_q < BI_W'(BYTES)) begin
                        state_d = SEND;
                    end else if (word_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + ADDR_W'(1);
                        rd_addr_d  = word_cnt_q + ADDR_W'(1);
                        rd_en_d    = 1'b1;
                        state_d    = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            wait_q     <= wait_d;
        end
    end

    assign rd_addr  = rd_addr_q;
    assign rd_en    = rd_en_q;
    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Directed bench for sum_tx_sequencer: RAM with 3-cycle latency and a UART
// model that drops tx_rdy for a programmable gap after each strobe.
module tb_sum_tx_sequencer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 40;
    localparam int BYTES  = 5;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              tx_rdy = 1'b1;
    logic [ADDR_W-1:0] rd_addr, word_cnt;
    logic              rd_en, tx_en, busy, done;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] p1, p2;

    int gap = 0;
    int rdy_cnt = 0;
    int cyc = 0;
    int b2b = 0;
    bit prev_en = 1'b0;
    logic [7:0] bytes_q[$];
    int times_q[$];
    int addr_q[$];

    always #5 clk = ~clk;

    sum_tx_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BYTES(BYTES), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .tx_data(tx_data), .tx_en(tx_en), .tx_rdy(tx_rdy),
        .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    // RAM: data appears RD_LAT cycles after the rd_en cycle; garbage otherwise
    always @(posedge clk) begin
        p1      <= rd_en ? ram[rd_addr[2:0]] : {DATA_W{1'b1}};
        p2      <= p1;
        rd_data <= p2;
    end

    always @(negedge clk) begin
        cyc++;
        if (tx_en) begin
            if (prev_en) b2b++;
            bytes_q.push_back(tx_data);
            times_q.push_back(cyc);
            rdy_cnt = gap;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
        end
        prev_en = tx_en;
        if (rd_en) addr_q.push_back(int'(rd_addr));
        tx_rdy = (rdy_cnt == 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bytes_q.delete();
        times_q.delete();
        addr_q.delete();
        b2b = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk(tag, {rd_addr, rd_en, tx_data, tx_en, busy, done, word_cnt}, 0);
    endtask

    task automatic check_stream(input string tag);
        int mism = 0;
        int abad = 0;
        logic [DATA_W-1:0] w;
        chk({tag, "_nbytes"}, bytes_q.size(), DEPTH * BYTES);
        for (int i = 0; i < bytes_q.size() && i < DEPTH * BYTES; i++) begin
            w = ram[i / BYTES];
            if (bytes_q[i] !== w[DATA_W-1 - 8*(i % BYTES) -: 8]) mism++;
        end
        chk({tag, "_bytes"}, mism, 0);
        chk({tag, "_naddr"}, addr_q.size(), DEPTH);
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] != i) abad++;
        chk({tag, "_addr_seq"}, abad, 0);
        chk({tag, "_b2b"}, b2b, 0);
    endtask

    initial begin
        int n, bad, nb, w0;
        ram[0] = 40'h0102030405;
        ram[1] = 40'hA1B2C3D4E5;
        for (int i = 2; i < DEPTH; i++)
            ram[i] = 40'h0F1E2D3C4B ^ {5{8'(i)}};

        repeat (3) tick();
        check_reset_outs("reset_outs");
        reset = 1'b0;
        tick();

        // first transfer, tx_rdy held high; latency of first read/strobe
        clr();
        gap = 0;
        pulse_start();
        chk("rd_en_c1", rd_en, 1);
        chk("rd_addr_c1", rd_addr, 0);
        chk("busy_c1", busy, 1);
        chk("done_c1", done, 0);
        tick();
        chk("rd_en_one_cycle", rd_en, 0);
        n = 2;
        while (!tx_en && n < 40) begin
            tick();
            n++;
        end
        chk("first_tx_latency", (n >= 2 + RD_LAT) && (n <= 3 + RD_LAT), 1);
        chk("first_byte", tx_data, 8'h01);
        wait_done(2000);
        chk("busy_after_done", busy, 0);
        chk("word_cnt_last", word_cnt, DEPTH - 1);
        check_stream("run1");
        bad = 0;
        for (int i = 1; i < times_q.size(); i++)
            if (i % BYTES != 0 && times_q[i] - times_q[i-1] != 2) bad++;
        chk("run1_spacing", bad, 0);

        // restart from DONE with a slow transmitter
        clr();
        gap = 10;
        pulse_start();
        chk("done_clears", done, 0);
        chk("busy_restart", busy, 1);
        wait_done(5000);
        check_stream("run2");
        bad = 0;
        for (int i = 1; i < times_q.size(); i++)
            if (times_q[i] - times_q[i-1] < 11) bad++;
        chk("run2_stall_gap", bad, 0);

        // start+abort together in DONE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_done_cleared", done, 0);
        chk("sa_busy", busy, 0);
        tick();
        chk("sa_no_read", rd_en, 0);

        // asynchronous reset after byte 2 of word 5
        clr();
        gap = 0;
        pulse_start();
        n = 0;
        while (bytes_q.size() < 5 * BYTES + 2 && n < 500) begin
            tick();
            n++;
        end
        chk("reach_w5_b2", bytes_q.size(), 5 * BYTES + 2);
        #3 reset = 1'b1;
        #1 check_reset_outs("async_reset_outs");
        tick();
        tick();
        reset = 1'b0;
        clr();
        pulse_start();
        wait_done(2000);
        check_stream("run3");

        // start while busy is ignored, then abort while stalled in SEND
        clr();
        gap = 10;
        pulse_start();
        n = 0;
        while (word_cnt < 2 && n < 1000) begin
            tick();
            n++;
        end
        w0 = int'(word_cnt);
        pulse_start();
        chk("start_busy_ignored", (int'(word_cnt) >= w0) && busy, 1);
        nb = bytes_q.size();
        n = 0;
        while (bytes_q.size() == nb && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] != i) bad++;
        chk("no_restart_addr", bad, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outs", {busy, done, tx_en, rd_en}, 0);
        chk("abort_word_cnt", word_cnt, 0);
        nb = bytes_q.size();
        repeat (60) tick();
        chk("abort_no_strobes", bytes_q.size(), nb);
        chk("abort_idle_busy", busy, 0);

        // start+abort together in IDLE: stays idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("sa_idle", {busy, rd_en, done}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sum_tx_sequencer.md
Name: sum_tx_sequencer

Overview:
Sequences transmission of the 40-bit beamformed sums from the sum RAM out through the communication block's UART transmitter. On start it reads DEPTH words in address order, waits the RAM read latency, and serialises each word MSB-first into BYTES bytes using the tx_en/tx_rdy handshake. It sits between the top-level controller (start/done) and the sum RAM read port plus the communication block's transmit interface.

Parameters:
DEPTH, 768, number of sum words to send (addresses 0..DEPTH-1)
ADDR_W, 10, sum RAM address width
DATA_W, 40, sum word width; must equal 8*BYTES
BYTES, 5, bytes per word
RD_LAT, 2, sum RAM read latency in cycles, rd_en/rd_addr to rd_data valid, >=1

Ports:
clk  in  1  system clock (PLL output)
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a transfer
abort  in  1  synchronous cancel
rd_addr  out  ADDR_W  sum RAM read address
rd_en  out  1  sum RAM read enable
rd_data  in  DATA_W  sum RAM read data
tx_data  out  8  byte to transmit
tx_en  out  1  one-cycle transmit strobe
tx_rdy  in  1  transmitter idle / ready for a byte
busy  out  1  high from accepted start until DONE or IDLE
done  out  1  level, high after all DEPTH words sent; cleared by next accepted start
word_cnt  out  ADDR_W  index of word currently being sent

Behaviour:
- Reset (any time, including mid-transfer): state IDLE; rd_addr=0, rd_en=0, tx_data=0, tx_en=0, busy=0, done=0, word_cnt=0, byte index=0, shift register=0.
- States: IDLE, READ, WAIT_RD, LOAD, SEND, GUARD, DONE.
- IDLE: start=1 -> READ, busy=1, done=0, word_cnt=0.
- DONE: busy=0, done=1; start=1 -> READ as from IDLE; otherwise hold.
- READ: rd_addr<=word_cnt, rd_en<=1 for exactly one cycle -> WAIT_RD.
- WAIT_RD: count RD_LAT-1 cycles after the rd_en cycle, with rd_en=0 -> LOAD.
- LOAD: capture rd_data into 40-bit shift register; byte index=0 -> SEND. From start accepted to first tx_en is 2+RD_LAT cycles minimum.
- SEND: wait until tx_rdy=1; in that cycle drive tx_data = shift[DATA_W-1 -: 8] with tx_en=1 for exactly one cycle, shift left by 8, increment byte index -> GUARD.
- GUARD: one cycle with tx_rdy ignored (transmitter drops tx_rdy the cycle after tx_en). Then if byte index<BYTES -> SEND; else if word_cnt==DEPTH-1 -> DONE; else word_cnt+1 -> READ.
- Byte order per word: bits [39:32], [31:24], [23:16], [15:8], [7:0].
- tx_data holds the last sent byte between strobes; tx_en is never high in two consecutive cycles.
- tx_rdy low stalls indefinitely in SEND with no timeout; no bytes are lost or duplicated.
- start while busy is ignored, with no restart or counter change.
- abort (priority over start, any non-IDLE state): next cycle IDLE, busy=0, done=0, tx_en=0, rd_en=0; counters cleared. A byte already strobed is not recalled.
- Simultaneous start and abort in IDLE/DONE: abort wins, result IDLE.
- word_cnt never exceeds DEPTH-1 and does not wrap; rd_addr is bounded likewise.
- Total strobes per completed transfer: exactly DEPTH*BYTES.

Test Plan:
1. DEPTH=2, RAM[0]=40'h0102030405, RAM[1]=40'hA1B2C3D4E5, tx_rdy tied 1, start pulse -> tx bytes 01,02,03,04,05,A1,B2,C3,D4,E5, each tx_en one cycle with strobes 2 cycles apart within a word; done=1, busy=0 afterwards.
2. RD_LAT=3, start at cycle 0 -> rd_en at cycle 1 with rd_addr=0, first tx_en no earlier than cycle 5, and tx_data equals the data presented at rd_en+3.
3. Model UART dropping tx_rdy for 10 cycles after each tx_en, DEPTH=768 -> exactly 3840 strobes, bytes match RAM MSB-first, rd_addr sequence 0..767 with no gaps or repeats.
4. Assert reset mid-word (after byte 2 of word 5) -> all outputs return to reset values immediately (asynchronously); a new start sends from word 0, byte 0.
5. Pulse start again while busy, then pulse abort during SEND -> the second start has no effect; after abort, IDLE next cycle, tx_en=0, done=0, and no further strobes occur.
6. After done=1, pulse start -> done clears the next cycle and the full sequence repeats identically.
